// File: rtl/frame_rr_scheduler_pkg.sv
// Shared types and helpers for the per-frame round-robin egress scheduler.
package frame_sched_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  // Index width for a port count; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_rr_scheduler_rr_pick.sv
// Rotating-priority encoder: first requester after last_grant_i, wrapping.
module rr_pick
  import frame_sched_pkg::*;
#(
  parameter int P_NUM_PORTS = 4,
  parameter int P_IW        = idx_width(P_NUM_PORTS)
) (
  input  logic [P_NUM_PORTS-1:0] req_i,
  input  logic [P_IW-1:0]        last_grant_i,
  output logic [P_IW-1:0]        grant_o,
  output logic                   found_o
);

  always_comb begin
    grant_o = last_grant_i;
    found_o = 1'b0;
    for (int i = 1; i <= P_NUM_PORTS; i++) begin
      if (!found_o && req_i[(int'(last_grant_i) + i) % P_NUM_PORTS]) begin
        grant_o = P_IW'((int'(last_grant_i) + i) % P_NUM_PORTS);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_rr_scheduler.sv
// Shares one egress datapath among FWFT ingress FIFOs, one frame per grant,
// with a beat watchdog that truncates frames lacking an end-of-frame marker.
//
// state  | meaning
// S_IDLE | no frame in flight; arbitrate among non-empty FIFOs
// S_XFER | draining one frame from the granted FIFO until EOF or beat limit
module frame_rr_scheduler
  import frame_sched_pkg::*;
#(
  parameter int P_NUM_PORTS  = 4,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_MAX_BEATS  = 512
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [P_NUM_PORTS-1:0]              fifo_empty_i,
  input  logic [P_NUM_PORTS*P_DATA_WIDTH-1:0] fifo_data_i,
  input  logic [P_NUM_PORTS-1:0]              fifo_eof_i,
  output logic [P_NUM_PORTS-1:0]              fifo_rd_o,
  output logic [P_DATA_WIDTH-1:0]             data_o,
  output logic                                valid_o,
  output logic                                last_o,
  input  logic                                ready_i,
  output logic [$clog2(P_NUM_PORTS)-1:0]      grant_o,
  output logic                                busy_o,
  output logic                                trunc_o
);

  localparam int IW = idx_width(P_NUM_PORTS);
  localparam int BW = $clog2(P_MAX_BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(P_MAX_BEATS - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            trunc_q, trunc_d;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            beat;
  logic            at_limit;

  rr_pick #(
    .P_NUM_PORTS (P_NUM_PORTS),
    .P_IW        (IW)
  ) u_rr_pick (
    .req_i        (~fifo_empty_i),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_idx),
    .found_o      (pick_found)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(P_NUM_PORTS - 1);
      beat_cnt_q   <= '0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      trunc_q      <= trunc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    trunc_d      = 1'b0;
    valid_o      = 1'b0;
    last_o       = 1'b0;
    fifo_rd_o    = '0;
    beat         = 1'b0;
    at_limit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = S_XFER;
        end
      end
      S_XFER: begin
        valid_o            = ~fifo_empty_i[grant_q];
        at_limit           = (beat_cnt_q == LAST_BEAT);
        last_o             = valid_o & (fifo_eof_i[grant_q] | at_limit);
        beat               = valid_o & ready_i;
        fifo_rd_o[grant_q] = beat;
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_o) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
            // A limit-forced last word without EOF means the frame was cut.
            trunc_d      = ~fifo_eof_i[grant_q];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_o  = fifo_data_i[int'(grant_q)*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign grant_o = grant_q;
  assign busy_o  = (state_q == S_XFER);
  assign trunc_o = trunc_q;

endmodule

// File: doc/frame_rr_scheduler.md
# frame_rr_scheduler

Output-port scheduler for the switch fabric: shares one egress datapath between P_NUM_PORTS ingress `sync_fifo_core` instances (built with P_FWFT=1) on a per-frame round-robin basis. It picks a non-empty ingress FIFO, drains exactly one frame from it (up to and including the end-of-frame word), then re-arbitrates. A beat watchdog bounds frame length, so a missing end-of-frame marker cannot lock the egress port.

## Interface
- P_NUM_PORTS, 4: number of ingress FIFOs (2..16).
- P_DATA_WIDTH, 32: payload width per FIFO word, excluding the EOF flag.
- P_MAX_BEATS, 512: maximum words per frame before forced truncation (≥2).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- fifo_empty_i  in  P_NUM_PORTS  per-FIFO `empty_o` (FWFT: head word valid when low).
- fifo_data_i  in  P_NUM_PORTS*P_DATA_WIDTH  per-FIFO head data; port k at bits [k*W +: W].
- fifo_eof_i  in  P_NUM_PORTS  per-FIFO head-word end-of-frame flag.
- fifo_rd_o  out  P_NUM_PORTS  per-FIFO read strobe (pop head word).
- data_o  out  P_DATA_WIDTH  egress data.
- valid_o  out  1  egress word valid.
- last_o  out  1  egress word is the frame's last word.
- ready_i  in  1  egress sink accepts the word; must not depend on valid_o.
- grant_o  out  $clog2(P_NUM_PORTS)  currently granted port.
- busy_o  out  1  frame transfer in progress.
- trunc_o  out  1  one-cycle pulse: frame truncated by the watchdog.

## Operation
- FSM states: S_IDLE, S_XFER.
- S_IDLE:
  - req = ~fifo_empty_i.
  - If req ≠ 0, select the first requesting port in rotating order starting at last_grant+1 (mod P_NUM_PORTS). Register it into grant_o, clear beat_cnt, go to S_XFER.
  - Otherwise stay in S_IDLE.
- S_XFER:
  - valid_o = ~fifo_empty_i[grant_o].
  - data_o = head data of the granted port.
  - beat = valid_o & ready_i. fifo_rd_o[grant_o] = beat; all other bits of fifo_rd_o are 0.
  - last_o = valid_o & (fifo_eof_i[grant_o] | beat_cnt == P_MAX_BEATS-1).
  - On a beat, beat_cnt increments.
  - On a beat with last_o: last_grant ← grant_o and the FSM goes to S_IDLE.
  - If that last beat had no EOF flag, trunc_o pulses in the following cycle. The remaining words of that frame are arbitrated later as a new frame.
- The granted FIFO going empty mid-frame stalls transfer: valid_o drops and the grant is held (no re-arbitration).
- busy_o = (state == S_XFER).
- Outside S_XFER: valid_o=0, last_o=0, fifo_rd_o=0, and data_o holds the granted port's head data (don't-care).
- beat_cnt width: $clog2(P_MAX_BEATS+1); it never wraps.

## Timing
- Reset values (asynchronous on rstn_i low):
  - state=S_IDLE, grant_o=0, last_grant=P_NUM_PORTS-1 (port 0 has first priority), beat_cnt=0, trunc_o=0.
  - valid_o=0, last_o=0, fifo_rd_o=0, busy_o=0.
- Arbitration latency: a request seen in S_IDLE at edge n gives valid_o in cycle n+1 (if the FIFO is still non-empty).
- Datapath is combinational from FIFO head to data_o. fifo_rd_o is combinational from ready_i.
- With ready_i held high and no stalls, an L-word frame takes L cycles of valid_o plus one S_IDLE cycle: throughput L/(L+1).
- ready_i low while valid_o is high: data_o, last_o and grant_o are held stable, and no pop occurs.
- Reset asserted mid-frame aborts immediately with no pop. The partial frame remains in the FIFO.
- Simultaneous requests from every port are served in order 0,1,2,3,0,… one frame each.

## Structure
- Package frame_sched_pkg holds:
  - State enum state_t {S_IDLE, S_XFER}.
  - Function for the index width ($clog2 wrapper, minimum 1).
- Sub-module rr_pick: a combinational rotating-priority encoder. Inputs are the req vector and last_grant. Outputs are the grant index and a found flag.
- Top-level module contains the FSM, beat counter, egress mux and read-strobe decode.

## Test plan
- Single frame: port 2 holds 3 words (EOF on word 3), ready_i=1 → valid_o high for 3 consecutive cycles, last_o on the 3rd, fifo_rd_o=4'b0100 for 3 cycles, grant_o=2.
- Fairness: all 4 ports each hold two 2-word frames → grant order 0,1,2,3,0,1,2,3; each frame takes 3 cycles.
- Backpressure: 4-word frame, ready_i low on beats 2 and 3 for 2 cycles each → data_o stable while stalled, exactly 4 pops, last_o only with word 4.
- Starvation mid-frame: FIFO empties after word 2 of 5, refilled 5 cycles later → valid_o low for 5 cycles, grant unchanged, the other requesting port is not served until EOF.
- Watchdog: P_MAX_BEATS=8, 12-word frame with no EOF → last_o on word 8, trunc_o pulse the next cycle, words 9–12 sent as a separate frame.
- Async reset: assert rstn_i during beat 2 of a frame → all outputs reach reset values without a clock edge, and the FIFO pop count is 1.
